demux_router: RTL and testbench

- Receive-side counterpart of the transaction-layer output mux.
- Accepts one serialized word stream (data_in/valid_in) and steers each word to one of four output lanes. The destination is taken from the word's top two bits.
- Holds up to 2 words in an internal FIFO to absorb per-lane downstream pause, and drives a pause back upstream when that FIFO is full.
- Gated by the same 4-bit one-hot link state the transaction-layer state machine produces.

---
 rtl/demux_router_if.sv | 34 +++
 rtl/demux_router.sv | 113 +++++++++++
 tb/tb_demux_router.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/demux_router_if.sv
// Bus bundle for demux_router: upstream word stream, link state, per-lane
// downstream pause, the four lane outputs and the FIFO status/drop counter.
interface demux_router_if #(
  parameter int DATA_W = 5,
  parameter int DROP_W = 4
);
  logic [3:0]        state;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic [3:0]        pause;
  logic [DATA_W-1:0] out0;
  logic [DATA_W-1:0] out1;
  logic [DATA_W-1:0] out2;
  logic [DATA_W-1:0] out3;
  logic              valid0;
  logic              valid1;
  logic              valid2;
  logic              valid3;
  logic              pause_up;
  logic              empty;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output state, data_in, valid_in, pause,
    input  out0, out1, out2, out3, valid0, valid1, valid2, valid3,
           pause_up, empty, drop_cnt
  );

  modport slave (
    input  state, data_in, valid_in, pause,
    output out0, out1, out2, out3, valid0, valid1, valid2, valid3,
           pause_up, empty, drop_cnt
  );
endinterface

// File: rtl/demux_router.sv
// Steers a serialized word stream onto four lanes chosen by the word's top two
// bits, through a small FIFO that absorbs per-lane pause and counts overflow drops.
module demux_router #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 2,
  parameter int DROP_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  demux_router_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [3:0] ST_FLUSH  = 4'b0001;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_out [4];
  logic [3:0]        r_valid;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_flush;
  logic              w_enable;
  logic              w_full;
  logic              w_is_empty;
  logic [DATA_W-1:0] w_head;
  logic [1:0]        w_head_lane;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_flush     = (bus.state == ST_FLUSH);
  assign w_enable    = (bus.state == ST_IDLE) || (bus.state == ST_ACTIVE);
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_is_empty  = (r_count == '0);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_lane = w_head[DATA_W-1 -: 2];

  // Full check uses the start-of-cycle count, so a same-cycle pop never frees
  // room for an arriving word.
  assign w_pop  = w_enable && !w_is_empty && !bus.pause[w_head_lane];
  assign w_push = w_enable && bus.valid_in && !w_full;
  assign w_drop = w_enable && bus.valid_in && w_full;

  // NOTE: storage has no reset; validity is tracked by r_count alone, which
  // keeps the array as plain flops/RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= '0;
      r_drop_cnt <= '0;
      for (int i = 0; i < 4; i++) r_out[i] <= '0;
    end else if (w_flush) begin
      r_valid    <= '0;
      r_drop_cnt <= '0;
      for (int i = 0; i < 4; i++) r_out[i] <= '0;
    end else begin
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
      if (w_pop) begin
        r_valid              <= 4'b0001 << w_head_lane;
        r_out[w_head_lane]   <= w_head;
      end else begin
        r_valid <= '0;
      end
    end
  end

  assign bus.out0     = r_out[0];
  assign bus.out1     = r_out[1];
  assign bus.out2     = r_out[2];
  assign bus.out3     = r_out[3];
  assign bus.valid0   = r_valid[0];
  assign bus.valid1   = r_valid[1];
  assign bus.valid2   = r_valid[2];
  assign bus.valid3   = r_valid[3];
  assign bus.pause_up = w_full;
  assign bus.empty    = w_is_empty;
  assign bus.drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_demux_router.sv
// Self-checking bench for demux_router: directed scenarios followed by random
// traffic, all compared against a queue-based model of the routing rules.
module tb_demux_router;

  localparam int DATA_W = 5;
  localparam int DEPTH  = 2;
  localparam int DROP_W = 4;

  logic clk = 1'b0;
  logic reset;

  demux_router_if #(.DATA_W(DATA_W), .DROP_W(DROP_W)) bus ();

  demux_router #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_out [4];
  logic [3:0]        m_valid;
  int                m_drop;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < 4; i++) m_out[i] = '0;
    m_valid = '0;
    m_drop  = 0;
  endtask

  // One clock edge of the routing rules, evaluated on the sampled inputs.
  task automatic model_step(input logic [3:0] st, input logic v,
                            input logic [DATA_W-1:0] d, input logic [3:0] p);
    bit was_full;
    int lane;
    if (st == 4'b0001) begin
      model_clear();
    end else if (st == 4'b0100 || st == 4'b1000) begin
      was_full = (mq.size() == DEPTH);
      m_valid  = '0;
      if (mq.size() > 0) begin
        lane = int'(mq[0] / (2 ** (DATA_W - 2)));
        if (!p[lane]) begin
          m_out[lane]   = mq.pop_front();
          m_valid[lane] = 1'b1;
        end
      end
      if (v) begin
        if (!was_full) mq.push_back(d);
        else if (m_drop < 2 ** DROP_W - 1) m_drop++;
      end
    end else begin
      m_valid = '0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out0"},  8'(bus.out0), 8'(m_out[0]));
    check({tag, ".out1"},  8'(bus.out1), 8'(m_out[1]));
    check({tag, ".out2"},  8'(bus.out2), 8'(m_out[2]));
    check({tag, ".out3"},  8'(bus.out3), 8'(m_out[3]));
    check({tag, ".valid"}, 8'({bus.valid3, bus.valid2, bus.valid1, bus.valid0}), 8'(m_valid));
    check({tag, ".pause_up"}, 8'(bus.pause_up), 8'(mq.size() == DEPTH));
    check({tag, ".empty"},    8'(bus.empty),    8'(mq.size() == 0));
    check({tag, ".drop_cnt"}, 8'(bus.drop_cnt), 8'(m_drop));
  endtask

  task automatic cycle(input string tag, input logic [3:0] st, input logic v,
                       input logic [DATA_W-1:0] d, input logic [3:0] p);
    bus.state    = st;
    bus.valid_in = v;
    bus.data_in  = d;
    bus.pause    = p;
    @(posedge clk);
    model_step(st, v, d, p);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] st;
    logic [3:0] pz;
    int r;

    reset        = 1'b1;
    bus.state    = 4'b0001;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.pause    = '0;
    model_clear();
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Basic routing, one word per lane
    cycle("route_a", 4'b0100, 1'b1, 5'b00011, 4'b0000);
    cycle("route_b", 4'b0100, 1'b1, 5'b01100, 4'b0000);
    cycle("route_c", 4'b0100, 1'b1, 5'b10101, 4'b0000);
    cycle("route_d", 4'b0100, 1'b1, 5'b11110, 4'b0000);
    cycle("route_e", 4'b0100, 1'b0, 5'b00000, 4'b0000);
    check("route_out3_direct", 8'(bus.out3), 8'h1E);

    // Backpressure on lane 1
    cycle("bp_a", 4'b0100, 1'b1, 5'b01001, 4'b0010);
    cycle("bp_b", 4'b0100, 1'b1, 5'b01010, 4'b0010);
    check("bp_pause_up_direct", 8'(bus.pause_up), 8'h1);
    cycle("bp_c", 4'b0100, 1'b1, 5'b01011, 4'b0010);
    check("bp_drop_direct", 8'(bus.drop_cnt), 8'h1);
    cycle("bp_rel_a", 4'b0100, 1'b0, 5'b00000, 4'b0000);
    cycle("bp_rel_b", 4'b0100, 1'b0, 5'b00000, 4'b0000);
    check("bp_rel_out1_direct", 8'(bus.out1), 8'h0A);
    cycle("bp_rel_c", 4'b0100, 1'b0, 5'b00000, 4'b0000);

    // Head-of-line blocking
    cycle("hol_a", 4'b1000, 1'b1, 5'b10000, 4'b0100);
    cycle("hol_b", 4'b1000, 1'b1, 5'b00001, 4'b0100);
    cycle("hol_c", 4'b1000, 1'b0, 5'b00000, 4'b0100);
    cycle("hol_d", 4'b1000, 1'b0, 5'b00000, 4'b0000);
    check("hol_lane2_direct", 8'(bus.valid2), 8'h1);
    cycle("hol_e", 4'b1000, 1'b0, 5'b00000, 4'b0000);
    check("hol_lane0_direct", 8'(bus.valid0), 8'h1);

    // Init state holds everything
    cycle("init_a", 4'b0010, 1'b1, 5'b00111, 4'b0000);
    cycle("init_b", 4'b0010, 1'b1, 5'b11000, 4'b0000);
    check("init_empty_direct", 8'(bus.empty), 8'h1);

    // Flush with two words queued
    cycle("fl_a", 4'b0100, 1'b1, 5'b00101, 4'b1111);
    cycle("fl_b", 4'b0100, 1'b1, 5'b10110, 4'b1111);
    cycle("fl_c", 4'b0001, 1'b1, 5'b11111, 4'b0000);
    check("fl_empty_direct", 8'(bus.empty), 8'h1);

    // Drop counter saturation
    cycle("sat_fill_a", 4'b0100, 1'b1, 5'b00010, 4'b0001);
    cycle("sat_fill_b", 4'b0100, 1'b1, 5'b00100, 4'b0001);
    for (int i = 0; i < 20; i++)
      cycle("sat", 4'b0100, 1'b1, 5'($urandom_range(0, 31)), 4'b0001);
    check("sat_direct", 8'(bus.drop_cnt), 8'h0F);

    // Async reset between edges with a full FIFO
    bus.valid_in = 1'b0;
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_all("async_rst");
    reset = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      case (r)
        0:       st = 4'b0001;
        1:       st = 4'b0010;
        2:       st = 4'($urandom_range(0, 15));
        default: st = (r < 12) ? 4'b0100 : 4'b1000;
      endcase
      pz = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      cycle("rand", st, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), pz);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
